// File: rtl/regfile_read_arbiter.sv
// Round-robin owner of the shared register-file read mux: grants 1-4 beat bursts,
// drives the select and returns the registered mux data tagged with the requester id.
module regfile_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*3-1:0]      req_len,
  output logic [ADDR_W-1:0]         mux_select,
  input  logic [DATA_W-1:0]         mux_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic [1:0]                rd_id,
  output logic                      rd_last
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t              state;
  logic [1:0]          owner;
  logic [1:0]          rr_ptr;
  logic [1:0]          beat;
  logic [1:0]          last_idx;
  logic [ADDR_W-1:0]   base;
  logic                last_beat;
  logic [NUM_REQ-1:0]  cand;
  logic [1:0]          ptr_eff;
  logic [2:0]          pick;
  logic [ADDR_W-1:0]   pick_addr;
  logic [2:0]          pick_len;

  // Burst length field -> index of the final beat (0 acts as 1, above 4 clamps to 4).
  function automatic logic [1:0] norm_last(input logic [2:0] l);
    if (l == 3'd0)
      return 2'd0;
    else if (l > 3'd4)
      return 2'd3;
    else
      return 2'(l - 3'd1);
  endfunction

  // Returns {found, index}: first set bit of r searching upward from ptr, wrapping.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign last_beat  = (state == ISSUE) && (beat == last_idx);
  assign mux_select = (state == ISSUE) ? base + ADDR_W'(beat) : '0;
  assign ack        = last_beat ? grant : '0;

  // Arbitrate when idle, or on the final beat so the next burst starts without a gap.
  assign cand      = (state == IDLE) ? req : (last_beat ? (req & ~ack) : '0);
  assign ptr_eff   = (state == ISSUE) ? owner + 2'd1 : rr_ptr;
  assign pick      = rr_pick(cand, ptr_eff);
  assign pick_addr = req_addr[pick[1:0]*ADDR_W +: ADDR_W];
  assign pick_len  = req_len[pick[1:0]*3 +: 3];

  always_ff @(posedge clock) begin
    if (pick[2]) begin
      base     <= pick_addr;
      last_idx <= norm_last(pick_len);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 2'd0;
      grant    <= '0;
      rr_ptr   <= 2'd0;
      beat     <= 2'd0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_id    <= 2'd0;
      rd_last  <= 1'b0;
    end else begin
      // Read-return stage: capture the mux output selected during this beat.
      rd_valid <= (state == ISSUE);
      if (state == ISSUE) begin
        rd_data <= mux_data;
        rd_id   <= owner;
        rd_last <= last_beat;
      end

      if (state == ISSUE && !last_beat) begin
        beat <= beat + 2'd1;
      end else if (pick[2]) begin
        state <= ISSUE;
        owner <= pick[1:0];
        grant <= NUM_REQ'(1) << pick[1:0];
        beat  <= 2'd0;
      end else if (state == ISSUE) begin
        state <= IDLE;
        grant <= '0;
        beat  <= 2'd0;
      end

      if (last_beat) rr_ptr <= owner + 2'd1;
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: queue-based burst model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regfile_read_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [19:0] req_addr = '0;
  logic [11:0] req_len = '0;
  logic [4:0]  mux_select;
  logic [31:0] mux_data;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [1:0]  rd_id;
  logic        rd_last;

  logic [31:0] regs [32];
  assign mux_data = regs[mux_select];

  regfile_read_arbiter #(.NUM_REQ(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clock(clock), .reset(reset), .req(req), .req_addr(req_addr), .req_len(req_len),
    .mux_select(mux_select), .mux_data(mux_data), .grant(grant), .ack(ack),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_id(rd_id), .rd_last(rd_last)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a burst is a queue of addresses still to be issued.
  int          mq[$];
  int          mown = 0;
  int          mptr = 0;
  bit          pv = 0;
  logic [31:0] pd = '0;
  int          pid = 0;
  bit          pl = 0;
  logic [3:0]  last_ack = '0;

  always @(negedge clock) begin : model
    bit          busy;
    logic [3:0]  e_grant, e_ack, avail;
    int          e_sel, w, n, a;
    bit          found;
    busy    = (mq.size() > 0);
    e_sel   = busy ? mq[0] : 0;
    e_grant = busy ? 4'(1 << mown) : 4'b0;
    e_ack   = (busy && mq.size() == 1) ? e_grant : 4'b0;
    last_ack = ack;
    check("grant", 32'(grant), 32'(e_grant));
    check("ack", 32'(ack), 32'(e_ack));
    check("mux_select", 32'(mux_select), 32'(e_sel));
    check("rd_valid", 32'(rd_valid), 32'(pv));
    if (pv) begin
      check("rd_data", rd_data, pd);
      check("rd_id", 32'(rd_id), 32'(pid));
      check("rd_last", 32'(rd_last), 32'(pl));
    end
    if (reset) begin
      mq.delete();
      mptr = 0;
      pv = 0;
    end else begin
      pv = busy;
      if (busy) begin
        pd  = regs[mq[0]];
        pid = mown;
        pl  = (mq.size() == 1);
      end
      avail = 4'b0;
      if (!busy) avail = req;
      else begin
        void'(mq.pop_front());
        if (mq.size() == 0) begin
          mptr  = (mown + 1) % 4;
          avail = req & ~4'(1 << mown);
        end
      end
      if (mq.size() == 0 && avail != 4'b0) begin
        found = 0;
        w = 0;
        for (int k = 0; k < 4; k++) begin
          if (!found && avail[(mptr + k) % 4]) begin
            found = 1;
            w = (mptr + k) % 4;
          end
        end
        n = int'(req_len[w*3 +: 3]);
        if (n == 0) n = 1;
        if (n > 4) n = 4;
        a = int'(req_addr[w*5 +: 5]);
        for (int j = 0; j < n; j++) mq.push_back((a + j) % 32);
        mown = w;
      end
    end
  end

  bit auto_drop = 1;
  bit rnd = 0;

  // Advance to just after the next rising edge; requesters release req after their ack.
  task automatic tick();
    @(posedge clock);
    #1;
    if (auto_drop) req = req & ~last_ack;
    if (rnd) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          req_addr[i*5 +: 5] = 5'($urandom);
          req_len[i*3 +: 3]  = 3'($urandom);
        end else if (req[i] && $urandom_range(0, 7) == 0) begin
          req_addr[i*5 +: 5] = 5'($urandom);
          req_len[i*3 +: 3]  = 3'($urandom);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0]  esel [4];
    logic [3:0]  eack [4];
    logic [1:0]  eid [4];
    logic [3:0]  eg [4];
    int          n;
    esel = '{5'd30, 5'd31, 5'd0, 5'd1};
    eack = '{4'b0000, 4'b0000, 4'b0000, 4'b0100};
    eid  = '{2'd1, 2'd1, 2'd3, 2'd3};
    eg   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    @(negedge clock);
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_ack", 32'(ack), 32'h0);
    check("reset_sel", 32'(mux_select), 32'h0);
    check("reset_rd_valid", 32'(rd_valid), 32'h0);
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_rd_id", 32'(rd_id), 32'h0);
    check("reset_rd_last", 32'(rd_last), 32'h0);

    // Single request, addr 7, len 1
    reset = 1'b0;
    req_addr[4:0] = 5'd7;
    req_len[2:0]  = 3'd1;
    req = 4'b0001;
    tick();
    @(negedge clock);
    check("single_grant", 32'(grant), 32'h1);
    check("single_sel", 32'(mux_select), 32'd7);
    check("single_ack", 32'(ack), 32'h1);
    tick();
    @(negedge clock);
    check("single_rd_valid", 32'(rd_valid), 32'h1);
    check("single_rd_data", rd_data, 32'h1000_0007);
    check("single_rd_id", 32'(rd_id), 32'h0);
    check("single_rd_last", 32'(rd_last), 32'h1);
    tick();
    @(negedge clock);
    check("single_idle_valid", 32'(rd_valid), 32'h0);
    check("single_idle_grant", 32'(grant), 32'h0);

    // Wrapping burst from 30, len 4
    req_addr[14:10] = 5'd30;
    req_len[8:6]    = 3'd4;
    req = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clock);
      check("wrap_sel", 32'(mux_select), 32'(esel[k]));
      check("wrap_ack", 32'(ack), 32'(eack[k]));
    end
    tick();
    @(negedge clock);
    check("wrap_last_data", rd_data, 32'h1000_0001);
    check("wrap_last_flag", 32'(rd_last), 32'h1);
    tick();
    tick();

    // Contention: requesters 1 and 3 from reset, len 2 each
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_len[5:3]  = 3'd2;
    req_len[11:9] = 3'd2;
    req_addr[9:5]   = 5'd12;
    req_addr[19:15] = 5'd20;
    req = 4'b1010;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clock);
      check("cont_valid", 32'(rd_valid), 32'h1);
      check("cont_id", 32'(rd_id), 32'(eid[k]));
    end
    tick();
    tick();

    // Fairness: all four held high, len 1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    auto_drop = 0;
    req_len = 12'b001_001_001_001;
    req = 4'b1111;
    tick();
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check("fair_grant", 32'(grant), 32'(eg[k % 4]));
      if (k > 0) check("fair_valid", 32'(rd_valid), 32'h1);
      tick();
    end
    req = 4'b0000;
    auto_drop = 1;
    tick();
    tick();
    tick();

    // Reset during beat 1 of a 4-beat burst
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_addr[4:0] = 5'd5;
    req_len[2:0]  = 3'd4;
    req = 4'b0001;
    tick();
    tick();
    reset = 1'b1;
    tick();
    @(negedge clock);
    check("rst_mid_grant", 32'(grant), 32'h0);
    check("rst_mid_ack", 32'(ack), 32'h0);
    check("rst_mid_valid", 32'(rd_valid), 32'h0);
    check("rst_mid_sel", 32'(mux_select), 32'h0);
    reset = 1'b0;
    req_len[5:3] = 3'd1;
    req = 4'b0011;
    tick();
    @(negedge clock);
    check("rst_mid_regrant", 32'(grant), 32'h1);
    repeat (8) tick();

    // Length normalisation: 0 -> one beat, 7 -> four beats
    req_addr[4:0] = 5'd10;
    req_len[2:0]  = 3'd0;
    req = 4'b0001;
    tick();
    @(negedge clock);
    check("len0_ack", 32'(ack), 32'h1);
    tick();
    @(negedge clock);
    check("len0_last", 32'(rd_last), 32'h1);
    check("len0_data", rd_data, 32'h1000_000a);
    tick();
    req_len[2:0] = 3'd7;
    req = 4'b0001;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      @(negedge clock);
      if (grant[0]) n++;
    end
    check("len7_beats", 32'(n), 32'd4);

    // Randomized traffic
    reset = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    tick();
    reset = 1'b0;
    rnd = 1;
    repeat (3000) tick();
    rnd = 0;
    reset = 1'b0;
    req = 4'b0000;
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_read_arbiter.md
Name: regfile_read_arbiter

Overview:
- Shares the single register-file read path (5-bit select into a 32:1 x 32-bit read mux) among NUM_REQ requesters, e.g. fetch/decode, debug, and a multicycle unit.
- Round-robin arbitration with burst support: a granted requester reads 1–4 consecutive registers, one per cycle.
- Drives the mux select directly and registers the returned mux data, tagged with the requester ID.
- Sits between the requesters and the register-file read mux.

Parameters:
- NUM_REQ, 4, number of requesters (fixed at 4 for this revision; ID width 2).
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level; held high until ack.
- req_addr  input  NUM_REQ*ADDR_W  base register address; requester i uses bits [5i+4:5i].
- req_len  input  NUM_REQ*3  burst length; requester i uses bits [3i+2:3i]. 0 is treated as 1; values above 4 saturate to 4.
- mux_select  output  ADDR_W  select to the read mux.
- mux_data  input  DATA_W  combinational data returned by the read mux.
- grant  output  NUM_REQ  one-hot, registered; current burst owner.
- ack  output  NUM_REQ  one-hot pulse during the owner's last beat.
- rd_valid  output  1  rd_data/rd_id/rd_last valid this cycle.
- rd_data  output  DATA_W  registered read data.
- rd_id  output  2  requester index for rd_data.
- rd_last  output  1  rd_data is the final beat of its burst.

Behaviour:
- Reset values (synchronous, wins over all other activity):
  - state=IDLE, grant=0, ack=0, mux_select=0, rr_ptr=0, beat=0.
  - rd_valid=0, rd_data=0, rd_id=0, rd_last=0.
- States: IDLE, ISSUE.
- IDLE:
  - mux_select=0, grant=0, ack=0.
  - At the edge where any req is high: pick the winner round-robin, searching from rr_ptr upward mod 4. The first set bit wins.
  - At that edge: latch base=req_addr[winner] and len=normalised req_len[winner]; set grant one-hot; beat=0; go to ISSUE.
- ISSUE, beat k:
  - mux_select = (base + k) mod 32. Address wraps 31->0.
  - ack[winner]=1 combinationally when k==len-1.
  - At the end of each beat: rd_data<=mux_data, rd_id<=winner, rd_last<=(k==len-1), rd_valid<=1. Data therefore appears exactly 1 cycle after its select.
- Burst completion, at the edge ending beat len-1:
  - rr_ptr <= winner+1 mod 4.
  - Re-arbitrate among req & ~ack, using the updated pointer. If any remain, start the next burst immediately with no idle cycle between bursts. Otherwise go to IDLE.
- rd_valid is 0 in any cycle not following an ISSUE beat.
- Latched values: base and len are sampled only at grant. Changes to req_addr or req_len during a burst are ignored.
- req dropped mid-burst: the burst still runs to completion. The requester must hold req until it sees ack.
- A requester may re-request immediately after its ack. It is then lowest priority relative to the others.
- Total latency, idle to first data: req high at edge N -> first select in cycle N+1 -> rd_valid in cycle N+2.
- Throughput: 1 register per cycle while requests are pending.
- Reset mid-burst: grant/ack drop next cycle and rd_valid=0 next cycle. The captured beat is discarded and the pointer returns to 0.

Test Plan:
- Single request: req[0]=1, addr=7, len=1, mux model returns 0x1000_0000+sel.
  - -> grant=0001 one cycle later, with mux_select=7 and ack[0]=1.
  - -> next cycle rd_valid=1, rd_data=0x1000_0007, rd_id=0, rd_last=1.
  - -> then rd_valid=0 and state IDLE.
- Wrap burst: req[2]=1, addr=30, len=4.
  - -> selects 30,31,0,1 on consecutive cycles.
  - -> rd_data follows one cycle later, rd_last only on the sel=1 data.
  - -> ack[2] only with sel=1.
- Contention: req[1] and req[3] rise together from reset (ptr=0), each len=2.
  - -> requester 1 served first, then requester 3 with no bubble.
  - -> rd_id sequence 1,1,3,3.
- Fairness: all four req held high continuously, len=1, and each requester re-requests after its ack.
  - -> grant order 0,1,2,3,0,1,… with rd_valid=1 every cycle after the first.
- Reset mid-burst: req[0], len=4, assert reset during beat 1.
  - -> next cycle grant=0, ack=0, rd_valid=0, mux_select=0.
  - -> after release with req[1] and req[0] high, requester 0 is granted first (ptr=0).
- Length normalisation: len=0 -> a single beat with rd_last=1. len=7 -> exactly 4 beats.
